scan_8seg_drv: RTL
==================

SCAN_8SEG_DRV -- requirements
Module: scan_8seg_drv

Interface
REQ-001 The block SHALL have parameter N_DIGITS, default 8, legal 1..16: number of multiplexed digits.
REQ-002 The block SHALL have parameter PRESCALE_LOG2, default 10: log2 of clocks per digit slot.
REQ-003 The block SHALL have parameter DIM_BITS, default 4, legal 1..PRESCALE_LOG2: brightness resolution.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 The block SHALL have port CLK, input, 1 bit: clock, all state on rising edge.
REQ-006 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port data, input, 4*N_DIGITS bits: hex nibbles, nibble k drives digit k (k=0 is least significant).
REQ-008 The block SHALL have port dots, input, N_DIGITS bits: decimal point per digit.
REQ-009 The block SHALL have port load, input, 1 bit: capture data/dots into the shadow register.
REQ-010 The block SHALL have port oe, input, 1 bit: display enable.
REQ-011 The block SHALL have port lz_blank, input, 1 bit: enable leading-zero blanking.
REQ-012 The block SHALL have port bright, input, DIM_BITS bits: duty level.
REQ-013 The block SHALL have port drains, output, N_DIGITS bits: one-hot digit select, active high.
REQ-014 The block SHALL have port leds, output, 8 bits: segments a..g at [6:0], dot at [7], active high.
REQ-015 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at end of each scan frame.

Function
REQ-016 The block SHALL sample data and dots into the shadow register and set the pending flag on every cycle with load=1; the last load before the frame boundary wins.
REQ-017 The block SHALL copy shadow to the active register and clear pending on the first cycle of digit-0 slot 0 (frame boundary), and on any cycle with oe=0; a simultaneous load SHALL re-set pending with the new values.
REQ-018 The block SHALL have a prescaler that counts 0..2^PRESCALE_LOG2-1; at terminal count the digit index SHALL advance, wrapping N_DIGITS-1 -> 0.
REQ-019 The block SHALL assert frame_done for exactly one cycle when the index wraps to 0.
REQ-020 The block SHALL assert the drain for the current digit only when the prescaler count is nonzero and prescaler bits [PRESCALE_LOG2-1 -: DIM_BITS] <= bright, giving a one-clock dead time per slot and a duty of (bright+1)/2^DIM_BITS.
REQ-021 The block SHALL blank a digit when lz_blank=1, its nibble is 0, its dot is 0, and all higher-index nibbles are 0 with their dots 0; digit 0 SHALL never be blanked.
REQ-022 The block SHALL keep the drain of a blanked digit inactive for its slot and leds=0.
REQ-023 The block SHALL drive leds with the hex segment pattern of the active nibble, with bit 7 = dot.
REQ-024 The block SHALL register drains and leds, which SHALL lag the prescaler/index by exactly one cycle.
REQ-025 The block SHALL force drains=0 and leds=0 while oe=0, with prescaler and index held at 0; scanning SHALL restart at digit 0, count 0 on the cycle oe returns to 1.
REQ-026 The block SHALL never drive more than one drain bit high in any cycle.

Reset
REQ-027 While RST=1, the block SHALL hold prescaler, index, shadow, active register, and pending at 0, with drains=0, leds=0, and frame_done=0.
REQ-028 The block SHALL, after RST deasserts mid-frame, restart scanning from digit 0 with the active register at 0.

Structure
REQ-029 The hex-to-7-segment table and segment bit positions SHALL live in the shared display package as constants.
REQ-030 The combinational nibble-to-segment decoder SHALL be a single sub-module, seg7_hex_lut; all other logic SHALL be inline.

Verification
REQ-031 With N_DIGITS=8, PRESCALE_LOG2=4, DIM_BITS=2, bright=3, oe=1, data=0x12345678, the bench SHALL observe drains sequencing 0x01..0x80, leds showing 8,7,...,1, each for 15 of 16 clocks, and frame_done every 128 clocks.
REQ-032 The bench SHALL issue a load of 0xDEADBEEF mid-frame and SHALL observe the display keep the old value until the frame boundary, then show the new value, with no mixed frame.
REQ-033 The bench SHALL set lz_blank=1, data=0x00000050, and dots=0 and SHALL observe digits 7..2 dark with drains never asserted, and digits 1 and 0 showing 5 and 0; with data=0, digit 0 SHALL show 0.
REQ-034 The bench SHALL set bright=0 with DIM_BITS=2, PRESCALE_LOG2=4 and SHALL observe each drain high for 3 clocks per slot, counts 1..3.
REQ-035 The bench SHALL drop oe for 5 cycles mid-slot and SHALL observe drains=0 and leds=0 the next cycle, and a restart at digit 0 after oe rises.
REQ-036 The bench SHALL assert RST asynchronously mid-slot and SHALL observe all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/scan_8seg_drv_pkg.sv
// Shared display constants for the multiplexed 7-segment scanner.
package scan_8seg_drv_pkg;

  typedef logic [6:0] seg7_t;

  // Bit positions of the segments inside the leds bus (active high).
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Hex digit to segment pattern, gfedcba order; entry 0 sits in the low bits.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39,  // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,  // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,  // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F   // 3 2 1 0
  };

endpackage

// File: rtl/scan_8seg_drv_seg7_hex_lut.sv
// Combinational nibble to 7-segment pattern lookup.
module seg7_hex_lut
  import scan_8seg_drv_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg7_t      o_seg
);

  assign o_seg = HEX_SEG[i_nibble];

endmodule

// File: rtl/scan_8seg_drv.sv
// Multiplexed 7-segment scanner with shadow/active frame buffering,
// leading-zero blanking and per-slot PWM dimming.
module scan_8seg_drv
  import scan_8seg_drv_pkg::*;
#(
  parameter int N_DIGITS      = 8,
  parameter int PRESCALE_LOG2 = 10,
  parameter int DIM_BITS      = 4
)(
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [4*N_DIGITS-1:0]   data,
  input  logic [N_DIGITS-1:0]     dots,
  input  logic                    load,
  input  logic                    oe,
  input  logic                    lz_blank,
  input  logic [DIM_BITS-1:0]     bright,
  output logic [N_DIGITS-1:0]     drains,
  output logic [7:0]              leds,
  output logic                    frame_done
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PRESCALE_LOG2-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0]         IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [PRESCALE_LOG2-1:0] r_cnt;
  logic [IDX_W-1:0]         r_idx;
  logic [4*N_DIGITS-1:0]    r_shadowData;
  logic [N_DIGITS-1:0]      r_shadowDots;
  logic [4*N_DIGITS-1:0]    r_activeData;
  logic [N_DIGITS-1:0]      r_activeDots;
  logic                     r_pending;
  logic [N_DIGITS-1:0]      r_drains;
  logic [7:0]               r_leds;
  logic                     r_frameDone;

  logic                     w_boundary;
  logic                     w_takeShadow;
  logic [4*N_DIGITS-1:0]    w_frameData;
  logic [N_DIGITS-1:0]      w_frameDots;
  logic [3:0]               w_nibble;
  logic                     w_dot;
  logic                     w_blank;
  logic                     w_upperZero;
  logic [N_DIGITS-1:0]      w_onehot;
  logic                     w_duty;
  seg7_t                    w_seg;
  logic [7:0]               w_ledsNext;

  // The first cycle of digit 0, count 0 opens a new frame. The frame shown
  // must already be the one being copied in, so the decoder reads the shadow
  // on that cycle instead of the not-yet-updated active register.
  assign w_boundary   = (r_cnt == '0) && (r_idx == '0);
  assign w_takeShadow = w_boundary && r_pending;
  assign w_frameData  = w_takeShadow ? r_shadowData : r_activeData;
  assign w_frameDots  = w_takeShadow ? r_shadowDots : r_activeDots;

  // Prescaler counter with a one-clock dead time at count 0 and PWM from the top bits.
  assign w_duty = (r_cnt != '0) && (r_cnt[PRESCALE_LOG2-1 -: DIM_BITS] <= bright);

  // Select the current digit's nibble/dot and decide leading-zero blanking, scanning from the top digit down.
  always_comb begin
    w_nibble    = '0;
    w_dot       = 1'b0;
    w_blank     = 1'b0;
    w_upperZero = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      w_upperZero = w_upperZero && (w_frameData[4*k +: 4] == 4'h0) && !w_frameDots[k];
      if (r_idx == IDX_W'(k)) begin
        w_nibble = w_frameData[4*k +: 4];
        w_dot    = w_frameDots[k];
        w_blank  = lz_blank && (k != 0) && w_upperZero;
      end
    end
  end

  // One-hot digit select built from the index.
  always_comb begin
    w_onehot = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      w_onehot[k] = (r_idx == IDX_W'(k));
    end
  end

  seg7_hex_lut u_lut (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  // Place segment pattern and dot on their bus positions.
  always_comb begin
    w_ledsNext               = '0;
    w_ledsNext[SEG_G:SEG_A]  = w_seg;
    w_ledsNext[SEG_DP]       = w_dot;
  end

  // Prescaler and digit index; held at zero while the display is disabled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (!oe) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CNT_MAX) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end
    end
  end

  // Shadow capture on load, shadow-to-active transfer at the frame boundary or while disabled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_shadowData <= '0;
      r_shadowDots <= '0;
      r_activeData <= '0;
      r_activeDots <= '0;
      r_pending    <= 1'b0;
    end else begin
      if (!oe || w_boundary) begin
        if (r_pending) begin
          r_activeData <= r_shadowData;
          r_activeDots <= r_shadowDots;
        end
        r_pending <= 1'b0;
      end
      if (load) begin
        r_shadowData <= data;
        r_shadowDots <= dots;
        r_pending    <= 1'b1;
      end
    end
  end

  // Registered outputs, one cycle behind the prescaler/index.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_drains    <= '0;
      r_leds      <= '0;
      r_frameDone <= 1'b0;
    end else if (!oe) begin
      r_drains    <= '0;
      r_leds      <= '0;
      r_frameDone <= 1'b0;
    end else begin
      r_drains    <= (w_duty && !w_blank) ? w_onehot : '0;
      r_leds      <= w_blank ? 8'h00 : w_ledsNext;
      r_frameDone <= (r_cnt == CNT_MAX) && (r_idx == IDX_LAST);
    end
  end

  assign drains     = r_drains;
  assign leds       = r_leds;
  assign frame_done = r_frameDone;

endmodule
